// File: rtl/fft_mag_scheduler_if.sv
// Stream bundle around the shared FFT-magnitude engine: two source channels,
// the engine operand/result streams, the routed result stream and status.
// The slave view belongs to the scheduler, the master view to its environment.
interface fft_mag_scheduler_if #(
    parameter int DATA_W  = 28,
    parameter int TUSER_W = 11,
    parameter int MAG_W   = 16
);
    logic               s0_tvalid;
    logic               s0_tready;
    logic               s0_tlast;
    logic [TUSER_W-1:0] s0_tuser;
    logic [DATA_W-1:0]  s0_re;
    logic [DATA_W-1:0]  s0_im;
    logic               s1_tvalid;
    logic               s1_tready;
    logic               s1_tlast;
    logic [TUSER_W-1:0] s1_tuser;
    logic [DATA_W-1:0]  s1_re;
    logic [DATA_W-1:0]  s1_im;
    logic               eng_tvalid;
    logic               eng_tlast;
    logic [TUSER_W-1:0] eng_tuser;
    logic [DATA_W-1:0]  eng_re;
    logic [DATA_W-1:0]  eng_im;
    logic               eng_res_tvalid;
    logic               eng_res_tlast;
    logic [TUSER_W-1:0] eng_res_tuser;
    logic [MAG_W-1:0]   eng_res_tdata;
    logic               m0_tvalid;
    logic               m1_tvalid;
    logic               m_tlast;
    logic [TUSER_W-1:0] m_tuser;
    logic [MAG_W-1:0]   m_tdata;
    logic               busy;
    logic               err;

    modport slave (
        input  s0_tvalid, s0_tlast, s0_tuser, s0_re, s0_im,
               s1_tvalid, s1_tlast, s1_tuser, s1_re, s1_im,
               eng_res_tvalid, eng_res_tlast, eng_res_tuser, eng_res_tdata,
        output s0_tready, s1_tready,
               eng_tvalid, eng_tlast, eng_tuser, eng_re, eng_im,
               m0_tvalid, m1_tvalid, m_tlast, m_tuser, m_tdata, busy, err
    );

    modport master (
        output s0_tvalid, s0_tlast, s0_tuser, s0_re, s0_im,
               s1_tvalid, s1_tlast, s1_tuser, s1_re, s1_im,
               eng_res_tvalid, eng_res_tlast, eng_res_tuser, eng_res_tdata,
        input  s0_tready, s1_tready,
               eng_tvalid, eng_tlast, eng_tuser, eng_re, eng_im,
               m0_tvalid, m1_tvalid, m_tlast, m_tuser, m_tdata, busy, err
    );
endinterface

// File: rtl/fft_mag_scheduler.sv
// Shares one FFT-magnitude engine between two FFT output channels. Whole
// frames are granted round-robin, accepted beats are registered into the
// engine, and an owner FIFO remembers which channel each in-flight frame
// belongs to so engine results can be steered back to that channel.
module fft_mag_scheduler #(
    parameter int DATA_W    = 28,
    parameter int TUSER_W   = 11,
    parameter int MAG_W     = 16,
    parameter int OWN_DEPTH = 4
) (
    input  logic                clk,
    input  logic                reset,
    fft_mag_scheduler_if.slave  bus
);
    localparam int               PTR_W    = $clog2(OWN_DEPTH);
    localparam int               CNT_W    = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(OWN_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    state_t             state_r, state_nxt_s;
    logic               rr_r, rr_nxt_s;
    logic               s0_tready_r, s1_tready_r;
    logic               acc0_s, acc1_s;
    logic               push_s, push_id_s, pop_s;
    logic               full_s, empty_s, head_s;
    logic               own_mem_r [OWN_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r, rd_ptr_r;
    logic [CNT_W-1:0]   count_r, count_nxt_s;
    logic               eng_tvalid_r, eng_tlast_r;
    logic [TUSER_W-1:0] eng_tuser_r;
    logic [DATA_W-1:0]  eng_re_r, eng_im_r;
    logic               m0_tvalid_r, m1_tvalid_r, m_tlast_r;
    logic [TUSER_W-1:0] m_tuser_r;
    logic [MAG_W-1:0]   m_tdata_r;
    logic               busy_r, err_r;

    // Beat acceptance, owner FIFO status and pop decision
    always_comb begin
        acc0_s  = bus.s0_tvalid & s0_tready_r;
        acc1_s  = bus.s1_tvalid & s1_tready_r;
        full_s  = (count_r == CNT_FULL);
        empty_s = (count_r == CNT_ZERO);
        head_s  = own_mem_r[rd_ptr_r];
        // A result with no recorded owner must not disturb the FIFO
        pop_s   = bus.eng_res_tvalid & bus.eng_res_tlast & ~empty_s;
    end

    // Grant FSM: frame-level round-robin, owner push on the grant edge
    always_comb begin
        state_nxt_s = state_r;
        rr_nxt_s    = rr_r;
        push_s      = 1'b0;
        push_id_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (!full_s && (bus.s0_tvalid || bus.s1_tvalid)) begin
                    push_s = 1'b1;
                    if (bus.s0_tvalid && bus.s1_tvalid) begin
                        push_id_s = rr_r;
                    end else begin
                        push_id_s = bus.s1_tvalid;
                    end
                    state_nxt_s = push_id_s ? GRANT1 : GRANT0;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            GRANT0: begin
                if (acc0_s && bus.s0_tlast) begin
                    state_nxt_s = IDLE;
                    rr_nxt_s    = 1'b1;
                end else begin
                    state_nxt_s = GRANT0;
                end
            end
            GRANT1: begin
                if (acc1_s && bus.s1_tlast) begin
                    state_nxt_s = IDLE;
                    rr_nxt_s    = 1'b0;
                end else begin
                    state_nxt_s = GRANT1;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Owner count after this edge; simultaneous push and pop cancel out
    always_comb begin
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + CNT_ONE;
            2'b01:   count_nxt_s = count_r - CNT_ONE;
            default: count_nxt_s = count_r;
        endcase
    end

    // State, round-robin pointer and registered ready strobes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            rr_r        <= 1'b0;
            s0_tready_r <= 1'b0;
            s1_tready_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            rr_r        <= rr_nxt_s;
            s0_tready_r <= (state_nxt_s == GRANT0);
            s1_tready_r <= (state_nxt_s == GRANT1);
        end
    end

    // Owner FIFO storage and pointers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < OWN_DEPTH; i++) begin
                own_mem_r[i] <= 1'b0;
            end
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= CNT_ZERO;
        end else begin
            if (push_s) begin
                own_mem_r[wr_ptr_r] <= push_id_s;
                wr_ptr_r            <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            count_r <= count_nxt_s;
        end
    end

    // Forward accepted beats to the engine one cycle later; data holds otherwise
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            eng_tvalid_r <= 1'b0;
            eng_tlast_r  <= 1'b0;
            eng_tuser_r  <= {TUSER_W{1'b0}};
            eng_re_r     <= {DATA_W{1'b0}};
            eng_im_r     <= {DATA_W{1'b0}};
        end else begin
            eng_tvalid_r <= acc0_s | acc1_s;
            if (acc1_s) begin
                eng_tlast_r <= bus.s1_tlast;
                eng_tuser_r <= bus.s1_tuser;
                eng_re_r    <= bus.s1_re;
                eng_im_r    <= bus.s1_im;
            end else if (acc0_s) begin
                eng_tlast_r <= bus.s0_tlast;
                eng_tuser_r <= bus.s0_tuser;
                eng_re_r    <= bus.s0_re;
                eng_im_r    <= bus.s0_im;
            end
        end
    end

    // Route engine results to the owning channel; track busy and sticky err
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m0_tvalid_r <= 1'b0;
            m1_tvalid_r <= 1'b0;
            m_tlast_r   <= 1'b0;
            m_tuser_r   <= {TUSER_W{1'b0}};
            m_tdata_r   <= {MAG_W{1'b0}};
            busy_r      <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            m0_tvalid_r <= bus.eng_res_tvalid & ~empty_s & ~head_s;
            m1_tvalid_r <= bus.eng_res_tvalid & ~empty_s & head_s;
            if (bus.eng_res_tvalid) begin
                m_tlast_r <= bus.eng_res_tlast;
                m_tuser_r <= bus.eng_res_tuser;
                m_tdata_r <= bus.eng_res_tdata;
            end
            if (bus.eng_res_tvalid && empty_s) begin
                err_r <= 1'b1;
            end
            busy_r <= (state_nxt_s != IDLE) || (count_nxt_s != CNT_ZERO);
        end
    end

    assign bus.s0_tready  = s0_tready_r;
    assign bus.s1_tready  = s1_tready_r;
    assign bus.eng_tvalid = eng_tvalid_r;
    assign bus.eng_tlast  = eng_tlast_r;
    assign bus.eng_tuser  = eng_tuser_r;
    assign bus.eng_re     = eng_re_r;
    assign bus.eng_im     = eng_im_r;
    assign bus.m0_tvalid  = m0_tvalid_r;
    assign bus.m1_tvalid  = m1_tvalid_r;
    assign bus.m_tlast    = m_tlast_r;
    assign bus.m_tuser    = m_tuser_r;
    assign bus.m_tdata    = m_tdata_r;
    assign bus.busy       = busy_r;
    assign bus.err        = err_r;
endmodule

// File: tb/tb_fft_mag_scheduler.sv
// Bench for fft_mag_scheduler: random frame sources, an in-order engine with
// fixed latency, and a queue-based reference of grant/owner/routing rules.
module tb_fft_mag_scheduler;
    localparam int DATA_W = 28, TUSER_W = 11, MAG_W = 16, OWN_DEPTH = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fft_mag_scheduler_if #(.DATA_W(DATA_W), .TUSER_W(TUSER_W), .MAG_W(MAG_W)) bus();

    fft_mag_scheduler #(.DATA_W(DATA_W), .TUSER_W(TUSER_W), .MAG_W(MAG_W), .OWN_DEPTH(OWN_DEPTH))
        dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct {
        int                 due;
        logic               last;
        logic [TUSER_W-1:0] user;
        logic [MAG_W-1:0]   mag;
    } res_t;

    int n_checks = 0, n_pass = 0, cyc = 0;
    // sources
    logic               en [2], src_have [2], src_last [2];
    logic [TUSER_W-1:0] src_user [2];
    logic [DATA_W-1:0]  src_re [2], src_im [2];
    int                 src_len [2];
    int                 gap_pct, fix_len, eng_lat, frames_done;
    logic               stop, spur;
    res_t               eq[$];
    // reference model
    int                 m_owner, m_rr;
    int                 oq[$];
    logic               e_rdy0, e_rdy1, e_ev, e_el, e_mv0, e_mv1, e_ml, e_busy, e_err;
    logic [TUSER_W-1:0] e_eu, e_mu;
    logic [DATA_W-1:0]  e_ere, e_eim;
    logic [MAG_W-1:0]   e_md;
    // DUT observations
    int                 grants[$];
    int                 cnt_m0, cnt_m1;
    logic               prev_rdy0, prev_rdy1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    endtask

    task automatic model_reset();
        m_owner = -1; m_rr = 0; oq.delete();
        {e_rdy0, e_rdy1, e_ev, e_el, e_mv0, e_mv1, e_ml, e_busy, e_err} = 9'd0;
        e_eu = '0; e_mu = '0; e_ere = '0; e_eim = '0; e_md = '0;
        prev_rdy0 = 1'b0; prev_rdy1 = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_s0_tready"}, bus.s0_tready, 64'd0);
        chk({tag, "_s1_tready"}, bus.s1_tready, 64'd0);
        chk({tag, "_eng_tvalid"}, bus.eng_tvalid, 64'd0);
        chk({tag, "_eng_tlast"}, bus.eng_tlast, 64'd0);
        chk({tag, "_eng_tuser"}, bus.eng_tuser, 64'd0);
        chk({tag, "_eng_re"}, bus.eng_re, 64'd0);
        chk({tag, "_eng_im"}, bus.eng_im, 64'd0);
        chk({tag, "_m0_tvalid"}, bus.m0_tvalid, 64'd0);
        chk({tag, "_m1_tvalid"}, bus.m1_tvalid, 64'd0);
        chk({tag, "_m_tlast"}, bus.m_tlast, 64'd0);
        chk({tag, "_m_tuser"}, bus.m_tuser, 64'd0);
        chk({tag, "_m_tdata"}, bus.m_tdata, 64'd0);
        chk({tag, "_busy"}, bus.busy, 64'd0);
        chk({tag, "_err"}, bus.err, 64'd0);
    endtask

    // next beat of channel c; a new frame starts after tlast
    task automatic next_beat(input int c);
        if (!src_have[c] || src_last[c]) begin
            src_len[c]  = (fix_len != 0) ? fix_len : int'($urandom_range(4, 1));
            src_user[c] = '0;
            if (stop) en[c] = 1'b0;
        end else begin
            src_user[c] = src_user[c] + 1'b1;
        end
        src_re[c]   = DATA_W'($urandom);
        src_im[c]   = DATA_W'($urandom);
        src_last[c] = (int'(src_user[c]) == src_len[c] - 1);
        src_have[c] = 1'b1;
    endtask

    task automatic init_src();
        src_have[0] = 1'b0; src_have[1] = 1'b0;
        next_beat(0); next_beat(1);
    endtask

    task automatic drive_src();
        bus.s0_tvalid = en[0] && (int'($urandom_range(99)) >= gap_pct);
        bus.s0_tlast  = src_last[0]; bus.s0_tuser = src_user[0];
        bus.s0_re     = src_re[0];   bus.s0_im    = src_im[0];
        bus.s1_tvalid = en[1] && (int'($urandom_range(99)) >= gap_pct);
        bus.s1_tlast  = src_last[1]; bus.s1_tuser = src_user[1];
        bus.s1_re     = src_re[1];   bus.s1_im    = src_im[1];
    endtask

    task automatic drive_res();
        res_t r;
        bus.eng_res_tvalid = 1'b0;
        if (spur) begin
            bus.eng_res_tvalid = 1'b1; bus.eng_res_tlast = 1'b1;
            bus.eng_res_tuser  = TUSER_W'($urandom); bus.eng_res_tdata = MAG_W'($urandom);
        end else if (eq.size() > 0 && eq[0].due <= cyc) begin
            r = eq.pop_front();
            bus.eng_res_tvalid = 1'b1; bus.eng_res_tlast = r.last;
            bus.eng_res_tuser  = r.user; bus.eng_res_tdata = r.mag;
        end
    endtask

    // one clock: drive, predict from the rules, advance, compare, bookkeep
    task automatic step();
        logic a0, a1, grant_new;
        int   nown;
        res_t r;
        drive_src();
        drive_res();
        a0 = (m_owner == 0) && bus.s0_tvalid;
        a1 = (m_owner == 1) && bus.s1_tvalid;
        e_ev = a0 | a1;
        if (a0) begin
            e_el = bus.s0_tlast; e_eu = bus.s0_tuser; e_ere = bus.s0_re; e_eim = bus.s0_im;
        end else if (a1) begin
            e_el = bus.s1_tlast; e_eu = bus.s1_tuser; e_ere = bus.s1_re; e_eim = bus.s1_im;
        end
        e_mv0 = 1'b0; e_mv1 = 1'b0;
        if (bus.eng_res_tvalid) begin
            e_ml = bus.eng_res_tlast; e_mu = bus.eng_res_tuser; e_md = bus.eng_res_tdata;
            if (oq.size() == 0) e_err = 1'b1;
            else if (oq[0] == 0) e_mv0 = 1'b1;
            else e_mv1 = 1'b1;
        end
        grant_new = 1'b0;
        nown      = m_owner;
        if (m_owner < 0) begin
            if (oq.size() < OWN_DEPTH && (bus.s0_tvalid || bus.s1_tvalid)) begin
                grant_new = 1'b1;
                if (bus.s0_tvalid && bus.s1_tvalid) nown = m_rr;
                else nown = bus.s0_tvalid ? 0 : 1;
            end
        end else if ((a0 && bus.s0_tlast) || (a1 && bus.s1_tlast)) begin
            m_rr = 1 - m_owner;
            nown = -1;
        end
        if (bus.eng_res_tvalid && bus.eng_res_tlast && oq.size() > 0) void'(oq.pop_front());
        if (grant_new) oq.push_back(nown);
        m_owner = nown;
        e_rdy0  = (nown == 0);
        e_rdy1  = (nown == 1);
        e_busy  = (nown >= 0) || (oq.size() != 0);

        @(posedge clk); #1; cyc++;

        chk("s0_tready", bus.s0_tready, e_rdy0);
        chk("s1_tready", bus.s1_tready, e_rdy1);
        chk("eng_tvalid", bus.eng_tvalid, e_ev);
        chk("eng_tlast", bus.eng_tlast, e_el);
        chk("eng_tuser", bus.eng_tuser, e_eu);
        chk("eng_re", bus.eng_re, e_ere);
        chk("eng_im", bus.eng_im, e_eim);
        chk("m0_tvalid", bus.m0_tvalid, e_mv0);
        chk("m1_tvalid", bus.m1_tvalid, e_mv1);
        chk("m_tlast", bus.m_tlast, e_ml);
        chk("m_tuser", bus.m_tuser, e_mu);
        chk("m_tdata", bus.m_tdata, e_md);
        chk("busy", bus.busy, e_busy);
        chk("err", bus.err, e_err);

        if (bus.s0_tready && !prev_rdy0) grants.push_back(0);
        if (bus.s1_tready && !prev_rdy1) grants.push_back(1);
        prev_rdy0 = bus.s0_tready; prev_rdy1 = bus.s1_tready;
        cnt_m0 += int'(bus.m0_tvalid);
        cnt_m1 += int'(bus.m1_tvalid);
        if (a0) begin if (src_last[0]) frames_done++; next_beat(0); end
        if (a1) begin if (src_last[1]) frames_done++; next_beat(1); end
        if (bus.eng_tvalid) begin
            r.due = cyc + eng_lat; r.last = bus.eng_tlast; r.user = bus.eng_tuser;
            r.mag = bus.eng_re[MAG_W-1:0] ^ bus.eng_im[MAG_W-1:0];
            eq.push_back(r);
        end
    endtask

    task automatic drain(input string tag);
        int budget = 800;
        stop = 1'b1;
        while ((en[0] || en[1] || m_owner >= 0 || oq.size() != 0 || eq.size() != 0) && budget > 0) begin
            step();
            budget--;
        end
        chk({tag, "_drain_in_budget"}, budget > 0, 64'd1);
        stop = 1'b0;
    endtask

    task automatic run_frames(input string tag, input int n);
        int budget = 1000;
        frames_done = 0;
        while (frames_done < n && budget > 0) begin step(); budget--; end
        chk({tag, "_frames_in_budget"}, budget > 0, 64'd1);
    endtask

    initial begin
        reset = 1'b1; stop = 1'b0; spur = 1'b0;
        gap_pct = 0; fix_len = 4; eng_lat = 5; frames_done = 0;
        en[0] = 1'b0; en[1] = 1'b0;
        bus.eng_res_tvalid = 1'b0; bus.eng_res_tlast = 1'b0;
        bus.eng_res_tuser = '0; bus.eng_res_tdata = '0;
        init_src(); drive_src(); model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        reset = 1'b0;

        // single 4-beat frame on channel 0, engine latency 5
        fix_len = 4; gap_pct = 0; eng_lat = 5; stop = 1'b1;
        init_src(); en[0] = 1'b1; en[1] = 1'b0; cnt_m0 = 0; cnt_m1 = 0;
        drain("single");
        chk("single_m0_beats", cnt_m0, 64'd4);
        chk("single_m1_beats", cnt_m1, 64'd0);

        // contention with 2-beat frames: grants alternate starting with channel 1
        fix_len = 2; eng_lat = 3; init_src(); en[0] = 1'b1; en[1] = 1'b1;
        grants.delete(); cnt_m0 = 0; cnt_m1 = 0;
        run_frames("contend", 6);
        drain("contend");
        chk("contend_grant_count_ge4", grants.size() >= 4, 64'd1);
        for (int i = 0; i < 4 && i < grants.size(); i++)
            chk("contend_grant_order", grants[i], (i % 2 == 0) ? 64'd1 : 64'd0);
        chk("contend_m0_eq_m1", cnt_m0, cnt_m1);

        // owner FIFO fills with a slow engine; later grants wait for pops
        fix_len = 2; eng_lat = 40; init_src(); en[0] = 1'b1; en[1] = 1'b1;
        run_frames("fifo_full", 9);
        drain("fifo_full");

        // random lengths, gaps and latency
        for (int k = 0; k < 3; k++) begin
            fix_len = 0; gap_pct = 30; eng_lat = int'($urandom_range(12, 1));
            init_src(); en[0] = 1'b1; en[1] = 1'b1;
            repeat (200) step();
            drain("random");
        end
        gap_pct = 0;

        // spurious result with nothing in flight
        spur = 1'b1; step(); spur = 1'b0;
        repeat (3) step();
        chk("spurious_err_sticky", bus.err, 64'd1);

        // reset during beat 2 of a channel-1 frame
        begin
            int budget = 40;
            fix_len = 4; eng_lat = 3; init_src(); en[0] = 1'b0; en[1] = 1'b1;
            while (!(src_user[1] == 2 && m_owner == 1) && budget > 0) begin step(); budget--; end
            chk("midreset_reached_beat2", budget > 0, 64'd1);
        end
        drive_src();
        reset = 1'b1; #1;
        check_all_zero("midreset");
        @(posedge clk); #1;
        reset = 1'b0;
        bus.eng_res_tvalid = 1'b0;
        eq.delete(); model_reset();
        fix_len = 2; init_src(); en[0] = 1'b1; en[1] = 1'b1;
        step();
        chk("postreset_first_grant_s0", bus.s0_tready, 64'd1);
        chk("postreset_first_grant_s1", bus.s1_tready, 64'd0);
        repeat (40) step();
        drain("postreset");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/fft_mag_scheduler.md
Name: fft_mag_scheduler

Overview:
- Shares one FFT-magnitude engine (28-bit re/im in, 16-bit magnitude out, no backpressure, tuser/tlast carried through) between two FFT output channels, e.g. two bearing-sensor channels.
- Grants whole frames to one channel at a time, round-robin at frame boundaries.
- Registers the granted beats into the engine.
- Records which channel owns each frame in flight and routes engine results back to that channel's output.

Parameters:
- DATA_W, 28, width of each re/im input word
- TUSER_W, 11, bin-index sideband width
- MAG_W, 16, engine magnitude result width
- OWN_DEPTH, 4, maximum frames in flight (owner FIFO depth, power of 2)

Ports:
- clk  in  1  clock; all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- s0_tvalid / s1_tvalid  in  1  channel 0/1 beat valid
- s0_tready / s1_tready  out  1  channel 0/1 beat accepted
- s0_tlast / s1_tlast  in  1  last bin of frame
- s0_tuser / s1_tuser  in  TUSER_W  bin index
- s0_re, s0_im / s1_re, s1_im  in  DATA_W  each; FFT real/imag
- eng_tvalid  out  1  beat to shared engine
- eng_tlast  out  1  frame end to engine
- eng_tuser  out  TUSER_W  bin index to engine
- eng_re, eng_im  out  DATA_W  each; operands to engine
- eng_res_tvalid  in  1  engine result valid
- eng_res_tlast  in  1  engine result frame end
- eng_res_tuser  in  TUSER_W  engine result bin index
- eng_res_tdata  in  MAG_W  engine magnitude
- m0_tvalid / m1_tvalid  out  1  result for channel 0/1
- m_tlast  out  1  shared result tlast
- m_tuser  out  TUSER_W  shared result bin index
- m_tdata  out  MAG_W  shared result data
- busy  out  1  state != IDLE or owner FIFO not empty
- err  out  1  sticky; result received with no owner recorded

Behaviour:
- Reset state:
  - All outputs 0.
  - State IDLE, owner FIFO empty, rr pointer = 0 (channel 0 preferred first), err = 0.
  - Reset asserted mid-frame aborts immediately; partially forwarded frames are not tracked.
- State machine IDLE / GRANT0 / GRANT1:
  - Leave IDLE only when the owner FIFO is not full and at least one sX_tvalid = 1.
  - Both valid: grant channel rr. Otherwise grant whichever channel is valid.
  - On entering GRANTx, push owner id x into the owner FIFO in the same edge.
- Handshake:
  - sX_tready = (state == GRANTx); it is registered and is never 1 in IDLE.
  - The engine never stalls, so beat accepted = sX_tvalid & sX_tready.
  - Gaps (tvalid = 0) inside a frame are allowed; the grant is held.
- Forwarding:
  - Each accepted beat appears on eng_* exactly 1 cycle later, with eng_tvalid = 1 for one cycle.
  - eng_* data holds its last value when eng_tvalid = 0.
- Frame end:
  - An accepted beat with tlast returns to IDLE on the next edge.
  - The rr pointer is set to the other channel.
  - This gives a minimum of 1 idle cycle between frames.
- Result routing (combinational from FIFO head, registered out, latency 1):
  - m_tdata / m_tuser / m_tlast register the eng_res_* fields.
  - m0_tvalid = eng_res_tvalid & head == 0; m1_tvalid = eng_res_tvalid & head == 1.
  - eng_res_tvalid & eng_res_tlast pops the FIFO.
- Owner FIFO boundaries:
  - Push and pop on the same edge are both honoured; count is unchanged.
  - FIFO full blocks new grants only; a frame already granted completes.
  - A result with the FIFO empty sets err, drives no mX_tvalid, and does not pop.
  - err clears only on reset.
- Frame length is not checked; it is defined solely by tlast.

Test Plan:
- Single frame: ch0 sends 4 beats, tuser 0..3, tlast on beat 3; engine echo-model latency 5 -> s0_tready rises 1 cycle after s0_tvalid; eng_* lag by 1 cycle; m0_tvalid 4 beats with tuser 0..3; m1_tvalid never; busy drops after the final result.
- Contention: both channels hold valid continuously, 2-beat frames -> grants alternate 0,1,0,1; results routed m0,m1,m0,m1; exactly one idle cycle between frames on eng_tvalid.
- Back-pressure by FIFO: OWN_DEPTH = 4, engine result latency 40 -> 5th frame grant waits until the first result tlast pops; then granted on the next edge.
- Simultaneous push/pop: grant edge coincides with a result tlast edge -> FIFO count unchanged; routing of the following results is correct.
- Spurious result: eng_res_tvalid = 1 with nothing in flight -> err = 1 and stays 1; m0_tvalid = m1_tvalid = 0.
- Reset mid-frame: assert reset during beat 2 of a ch1 frame -> all outputs 0 immediately; after release, ch0 is granted first when both are valid.
